// File: rtl/dac_playback_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : dac_playback_feeder
//  Description : Upstream stage of the DAC output path. Buffers producer
//                samples in a small FIFO and releases them at a programmable
//                rate under a start/stop state machine. It drives the DAC
//                word, a DAC enable and a sticky underrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_playback_feeder #(
    parameter int               WIDTH     = 14,
    parameter int               AW        = 4,
    parameter int               DIV_W     = 8,
    parameter logic [WIDTH-1:0] IDLE_CODE = 14'h2000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [AW:0]      prime_lvl,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             dac_en,
    output logic [AW:0]      level,
    output logic             underrun,
    input  logic             clr_underrun,
    output logic             busy
);

    localparam int          c_DEPTH     = 1 << AW;
    localparam logic [AW:0] c_DEPTH_LVL = (AW+1)'(c_DEPTH);
    localparam logic [AW:0] c_ONE_LVL   = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mem [c_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_level;
    logic [DIV_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_out;
    logic               r_dac_en;
    logic               r_underrun;

    logic               w_in_ready;
    logic               w_wr;
    logic               w_strobe;
    logic               w_pop;
    logic               w_underrun_evt;
    logic               w_enter_run;
    logic [AW:0]        w_prime_tgt;

    // A stop cycle discards any presented write; stop also masks the strobe
    // so neither a pop nor an underrun can happen alongside a flush.
    assign w_in_ready     = (r_level != c_DEPTH_LVL);
    assign w_wr           = in_valid & w_in_ready & ~stop;
    assign w_strobe       = (r_state == S_RUN) && (r_count == div);
    assign w_pop          = w_strobe && (r_level != '0) && !stop;
    assign w_underrun_evt = w_strobe && (r_level == '0) && !stop;
    assign w_prime_tgt    = (prime_lvl == '0) ? c_ONE_LVL : prime_lvl;
    assign w_enter_run    = (r_state == S_PRIME) && (w_state_nxt == S_RUN);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                if (r_level >= w_prime_tgt) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_underrun_evt) begin
                    w_state_nxt = S_PRIME;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (stop) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Rate divider: held at zero outside RUN so every entry to RUN starts
    // from zero; div is compared live, so lowering it below the count lets
    // the count wrap around its full range.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (r_state != S_RUN || w_strobe) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DIV_W'(1);
        end
    end

    // FIFO storage; contents need no reset since the level gates reads.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; stop flushes everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (stop) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + c_ONE_LVL;
                2'b01:   r_level <= r_level - c_ONE_LVL;
                default: r_level <= r_level;
            endcase
        end
    end

    // DAC word and enable; PRIME keeps both so a re-prime after underrun
    // holds the last sample with the DAC still enabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out    <= IDLE_CODE;
            r_dac_en <= 1'b0;
        end else if (stop) begin
            r_out    <= IDLE_CODE;
            r_dac_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out    <= IDLE_CODE;
                    r_dac_en <= 1'b0;
                end
                S_PRIME: begin
                    if (w_enter_run) begin
                        r_dac_en <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_pop) begin
                        r_out <= r_mem[r_rd_ptr];
                    end
                end
                default: begin
                    r_out    <= IDLE_CODE;
                    r_dac_en <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underrun; a new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_evt) begin
            r_underrun <= 1'b1;
        end else if (clr_underrun) begin
            r_underrun <= 1'b0;
        end
    end

    assign in_ready = w_in_ready;
    assign out      = r_out;
    assign dac_en   = r_dac_en;
    assign level    = r_level;
    assign underrun = r_underrun;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dac_playback_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_playback_feeder
//  Description : Self-checking bench for dac_playback_feeder: a per-cycle
//                vector table for the underrun/re-prime flow plus directed
//                sequences for fill, playback, write+pop, reset and stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_playback_feeder;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        stop;
    logic [7:0]  div;
    logic [4:0]  prime_lvl;
    logic [13:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] out;
    logic        dac_en;
    logic [4:0]  level;
    logic        underrun;
    logic        clr_underrun;
    logic        busy;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        start;
        logic        stop;
        logic        vld;
        logic [13:0] data;
        logic        clr;
        logic [13:0] exp_out;
        logic        exp_en;
        logic [4:0]  exp_lvl;
        logic        exp_busy;
        logic        exp_ur;
    } vec_t;

    vec_t vecs [16];

    dac_playback_feeder dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .stop         (stop),
        .div          (div),
        .prime_lvl    (prime_lvl),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out          (out),
        .dac_en       (dac_en),
        .level        (level),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // start stop vld data clr | out en lvl busy ur
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 14'h0011, 1'b0, 14'h2000, 1'b0, 5'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 14'h0022, 1'b0, 14'h2000, 1'b0, 5'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h2000, 1'b0, 5'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h2000, 1'b1, 5'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0011, 1'b1, 5'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0022, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0022, 1'b1, 5'd0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 14'h0033, 1'b0, 14'h0022, 1'b1, 5'd1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 14'h0044, 1'b1, 14'h0022, 1'b1, 5'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0022, 1'b1, 5'd2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0033, 1'b1, 5'd1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0044, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 14'h0044, 1'b1, 5'd0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 14'h0055, 1'b0, 14'h2000, 1'b0, 5'd0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 14'h0000, 1'b0, 14'h2000, 1'b0, 5'd0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 14'h2000, 1'b0, 5'd0, 1'b0, 1'b0};

        resetn       = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        div          = 8'd0;
        prime_lvl    = 5'd2;
        in_data      = '0;
        in_valid     = 1'b0;
        clr_underrun = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        chk("reset.out",      32'(out),      32'h2000);
        chk("reset.dac_en",   32'(dac_en),   32'd0);
        chk("reset.level",    32'(level),    32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.busy",     32'(busy),     32'd0);
        chk("reset.underrun", 32'(underrun), 32'd0);

        // Underrun, re-prime, set-vs-clear, stop with write, start+stop.
        for (int i = 0; i < 16; i++) begin
            start        = vecs[i].start;
            stop         = vecs[i].stop;
            in_valid     = vecs[i].vld;
            in_data      = vecs[i].data;
            clr_underrun = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d.out", i),      32'(out),      32'(vecs[i].exp_out));
            chk($sformatf("vec%0d.dac_en", i),   32'(dac_en),   32'(vecs[i].exp_en));
            chk($sformatf("vec%0d.level", i),    32'(level),    32'(vecs[i].exp_lvl));
            chk($sformatf("vec%0d.busy", i),     32'(busy),     32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d.underrun", i), 32'(underrun), 32'(vecs[i].exp_ur));
        end
        start        = 1'b0;
        stop         = 1'b0;
        in_valid     = 1'b0;
        clr_underrun = 1'b0;

        // Fill to full in IDLE, then play all 17 samples at div=2.
        div       = 8'd2;
        prime_lvl = 5'd4;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data  = 14'(i + 1);
            tick();
            if (i == 15) begin
                chk("fill.in_ready_at_16", 32'(in_ready), 32'd0);
            end
        end
        chk("fill.level", 32'(level), 32'd16);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("play.busy_edge1",   32'(busy),   32'd1);
        chk("play.dac_en_edge1", 32'(dac_en), 32'd0);
        tick();
        chk("play.dac_en_edge2", 32'(dac_en), 32'd1);
        for (int k = 0; k < 17; k++) begin
            for (int t = 0; t < 3; t++) begin
                tick();
                if (k == 1 && t == 0) begin
                    chk("play.17th_accepted", 32'(level), 32'd16);
                    in_valid = 1'b0;
                end
            end
            chk($sformatf("play.out%0d", k),   32'(out),   32'(k + 1));
            chk($sformatf("play.level%0d", k), 32'(level), 32'(16 - k - ((k == 0) ? 0 : 0)) - ((k == 0) ? 32'd1 : 32'd0));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("play.stop_busy", 32'(busy), 32'd0);

        // Simultaneous write and pop at level 3.
        div       = 8'd0;
        prime_lvl = 5'd3;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 14'(14'h0100 + i);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("wrpop.level_before", 32'(level), 32'd3);
        in_valid = 1'b1;
        in_data  = 14'h0103;
        tick();
        in_valid = 1'b0;
        chk("wrpop.out",   32'(out),   32'h0100);
        chk("wrpop.level", 32'(level), 32'd3);

        // Asynchronous reset mid-run.
        #2;
        resetn = 1'b0;
        #1;
        chk("areset.out",    32'(out),    32'h2000);
        chk("areset.dac_en", 32'(dac_en), 32'd0);
        chk("areset.level",  32'(level),  32'd0);
        chk("areset.busy",   32'(busy),   32'd0);
        resetn = 1'b1;
        tick();

        // Stop mid-run at level 5 with a write in the stop cycle.
        div       = 8'd7;
        prime_lvl = 5'd5;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 14'(14'h0200 + i);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("stop.run_dac_en", 32'(dac_en), 32'd1);
        chk("stop.run_level",  32'(level),  32'd5);
        stop     = 1'b1;
        in_valid = 1'b1;
        in_data  = 14'h0BAD;
        tick();
        stop     = 1'b0;
        in_valid = 1'b0;
        chk("stop.level",  32'(level),  32'd0);
        chk("stop.out",    32'(out),    32'h2000);
        chk("stop.dac_en", 32'(dac_en), 32'd0);
        chk("stop.busy",   32'(busy),   32'd0);
        tick();
        chk("stop.write_discarded", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_playback_feeder.md
Name: dac_playback_feeder

Overview:
- Upstream stage of the DAC output path. Buffers samples from a producer, such as the bus/DMA side or a signal generator, in a small FIFO.
- Releases buffered samples at a programmable rate, gated by a start/stop state machine.
- Drives the DAC data word plus an active-high enable; the enable forces the downstream DDR output stage to zero when low.
- Detects underrun: FIFO empty at a release instant.

Parameters:
- WIDTH, 14, sample/DAC word width.
- AW, 4, FIFO address width; depth DEPTH = 2^AW.
- DIV_W, 8, width of the rate divider setting.
- IDLE_CODE, 14'h2000, value driven on out while not running (midscale).

Ports:
- clk  in  1  system clock, also the DAC output clock domain
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begin playback (IDLE -> PRIME)
- stop  in  1  pulse; abort playback, flush FIFO
- div  in  DIV_W  release period minus 1 (one sample every div+1 clocks)
- prime_lvl  in  AW+1  FIFO level required before RUN; 0 is treated as 1
- in_data  in  WIDTH  producer sample
- in_valid  in  1  producer sample valid
- in_ready  out  1  FIFO not full
- out  out  WIDTH  DAC sample word, registered
- dac_en  out  1  DAC enable, registered, active high
- level  out  AW+1  current FIFO occupancy, 0..DEPTH
- underrun  out  1  sticky underrun flag
- clr_underrun  in  1  clears underrun
- busy  out  1  state != IDLE

Behaviour:
- Reset (resetn=0, async): state=IDLE, out=IDLE_CODE, dac_en=0, level=0, underrun=0, divider count=0, FIFO pointers=0. in_ready=1 after reset.
- FIFO write: occurs on in_valid & in_ready. in_ready = (level != DEPTH), combinational from level. Writes are accepted in every state except the cycle in which stop is asserted.
- FIFO read (pop): only on a release strobe in RUN with level != 0.
  - Simultaneous write+pop: level unchanged.
  - Write at full: blocked by in_ready.
  - Pop at empty: never happens; the underrun path is taken instead.
  - Pointers wrap modulo DEPTH.
- Divider: count is cleared on entry to RUN and increments each RUN cycle. strobe = (count == div), after which count returns to 0. div=0 gives a strobe every clock. div is sampled live; if div is lowered below count, count is allowed to wrap through 2^DIV_W.
- States:
  - IDLE: out=IDLE_CODE, dac_en=0. start -> PRIME.
  - PRIME: out holds its last value; dac_en keeps its previous value (0 from IDLE, 1 on re-prime). When level >= max(prime_lvl,1) -> RUN, with count=0 and dac_en=1 registered on the same edge.
  - RUN, on strobe:
    - if level != 0: pop, and out <= FIFO head on that edge (1-cycle latency from strobe to out).
    - if level == 0: underrun <= 1, out holds its last value, state -> PRIME (re-prime; dac_en stays 1).
- stop, from any state, takes priority over start and over strobe:
  - next edge: state=IDLE, FIFO flushed (level=0), out=IDLE_CODE, dac_en=0.
  - A write presented in the stop cycle is discarded.
- start while busy: ignored.
- underrun: set has priority over clr_underrun in the same cycle. underrun is not cleared by stop or start; only clr_underrun or reset clear it.
- busy: combinational, (state != IDLE).
- First-sample latency: with the FIFO already at prime level when start arrives:
  - PRIME is entered at edge 1; RUN at edge 2 (dac_en=1).
  - The strobe occurs div cycles later; out shows sample 0 one edge after that strobe.
- Reset mid-operation: all state lost immediately. Outputs return to their reset values asynchronously.

Test Plan:
- Reset then idle:
  - Stimulus: hold resetn=0, release, apply no stimulus.
  - Required: out=0x2000, dac_en=0, level=0, in_ready=1, busy=0, underrun=0.
- Basic playback:
  - Stimulus: write 0x0001..0x0008, prime_lvl=4, div=2, start pulse.
  - Required: dac_en rises 2 edges after start.
  - Required: out steps 0x0001..0x0008, one value every 3 clocks; level decrements 8 -> 0.
- Fill to full:
  - Stimulus: write 17 samples back-to-back in IDLE with DEPTH=16.
  - Required: in_ready falls after the 16th accept; level=16; the 17th is held off and accepted after the first pop in RUN.
- Underrun and re-prime:
  - Stimulus: div=0, prime_lvl=2, 2 samples written, start.
  - Required: out shows both samples; on the 3rd strobe underrun=1, out holds the 2nd sample, state=PRIME with dac_en=1.
  - Stimulus: write 2 more samples.
  - Required: RUN resumes.
  - Stimulus: clr_underrun.
  - Required: underrun=0.
- Stop mid-run:
  - Stimulus: stop asserted while level=5 in RUN, with in_valid high the same cycle.
  - Required: next edge level=0, out=0x2000, dac_en=0, busy=0; the sample presented in the stop cycle is not stored.
- Simultaneous events:
  - Stimulus: start+stop in the same cycle from IDLE.
  - Required: stays IDLE.
  - Stimulus: set and clr_underrun in the same cycle.
  - Required: underrun=1.
  - Stimulus: write+pop at level=3.
  - Required: level stays 3.
